// File: rtl/resumption_replay_dev.sv
// rtl/resumption_replay_dev.sv - capture/replay ring-buffer stage with tag-register FSM
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   __in0  : W-bit data word to capture
//   __in1  : command (0 NOP, 1 PUSH, 2 REPLAY, 3 CLEAR)
//   __out0 : replayed-data valid
//   __out1 : replayed word, IDLE_VAL when __out0 is low
//   __out2 : occupancy count (0..DEPTH)
//   __out3 : sticky drop flag (PUSH refused because buffer full or replay busy)
module resumption_replay_dev #(
  parameter int            W        = 3,
  parameter int            DEPTH    = 4,
  parameter logic [W-1:0]  IDLE_VAL = '0,
  localparam int           CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  __in0,
  input  logic [1:0]    __in1,
  output logic          __out0,
  output logic [W-1:0]  __out1,
  output logic [CW-1:0] __out2,
  output logic          __out3
);

  localparam int PW = $clog2(DEPTH);

  // NOP (2'd0) falls through to the default arms below.
  localparam logic [1:0] CMD_PUSH   = 2'd1;
  localparam logic [1:0] CMD_REPLAY = 2'd2;
  localparam logic [1:0] CMD_CLEAR  = 2'd3;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REPLAY = 1'b1
  } state_t;

  // The whole resumption state lives in one tag register.
  typedef struct packed {
    state_t        state;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
  } tag_t;

  tag_t         tag;
  logic [W-1:0] mem [DEPTH];
  logic         full;
  logic         wr_en;

  assign full   = (tag.count == CW'(DEPTH));
  // Writes are only accepted in IDLE; a PUSH during replay is refused.
  assign wr_en  = rst && (tag.state == S_IDLE) && (__in1 == CMD_PUSH) && !full;
  assign __out2 = tag.count;

  // Buffer contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tag.wr_ptr] <= __in0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag.state  <= S_IDLE;
      tag.rd_ptr <= '0;
      tag.wr_ptr <= '0;
      tag.count  <= '0;
      __out0     <= 1'b0;
      __out1     <= IDLE_VAL;
      __out3     <= 1'b0;
    end else begin
      __out0 <= 1'b0;
      __out1 <= IDLE_VAL;
      if (__in1 == CMD_CLEAR) begin
        // CLEAR wins over everything, including an in-flight replay word.
        tag.state  <= S_IDLE;
        tag.rd_ptr <= '0;
        tag.wr_ptr <= '0;
        tag.count  <= '0;
        __out3     <= 1'b0;
      end else if (tag.state == S_REPLAY) begin
        // count is always >0 here; the edge emitting the last word returns to IDLE.
        __out0     <= 1'b1;
        __out1     <= mem[tag.rd_ptr];
        tag.rd_ptr <= tag.rd_ptr + PW'(1);
        tag.count  <= tag.count - CW'(1);
        if (tag.count == CW'(1)) begin
          tag.state <= S_IDLE;
        end
        if (__in1 == CMD_PUSH) begin
          __out3 <= 1'b1;
        end
      end else begin
        case (__in1)
          CMD_PUSH: begin
            if (full) begin
              __out3 <= 1'b1;
            end else begin
              tag.wr_ptr <= tag.wr_ptr + PW'(1);
              tag.count  <= tag.count + CW'(1);
            end
          end
          CMD_REPLAY: begin
            if (tag.count != '0) begin
              __out0     <= 1'b1;
              __out1     <= mem[tag.rd_ptr];
              tag.rd_ptr <= tag.rd_ptr + PW'(1);
              tag.count  <= tag.count - CW'(1);
              tag.state  <= (tag.count == CW'(1)) ? S_IDLE : S_REPLAY;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_resumption_replay_dev.sv
// tb/tb_resumption_replay_dev.sv - directed bench for resumption_replay_dev
module tb_resumption_replay_dev;

  localparam logic [1:0] NOP    = 2'd0;
  localparam logic [1:0] PUSH   = 2'd1;
  localparam logic [1:0] REPLAY = 2'd2;
  localparam logic [1:0] CLEAR  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] din = 3'd0;
  logic [1:0] cmd = NOP;
  logic       vld;
  logic [2:0] dout;
  logic [2:0] cnt;
  logic       drop;
  logic [7:0] obs;
  logic [7:0] e;

  int checks = 0;
  int errors = 0;

  assign obs = {vld, dout, cnt, drop};

  always #5 clk = ~clk;

  resumption_replay_dev #(.W(3), .DEPTH(4), .IDLE_VAL(3'd0)) dut (
    .clk    (clk),
    .rst    (rst),
    .__in0  (din),
    .__in1  (cmd),
    .__out0 (vld),
    .__out1 (dout),
    .__out2 (cnt),
    .__out3 (drop)
  );

  // Apply a command for one edge, then settle 1 time unit past the edge.
  task automatic step(input logic [1:0] c, input logic [2:0] d);
    cmd = c;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd = NOP;
    @(posedge clk);
    @(posedge clk);
    #1;
    e = {1'b0, 3'd0, 3'd0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL reset_held got %b exp %b", obs, e); end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(NOP, 3'd7);
      checks++; if (obs !== e) begin errors++; $display("FAIL reset_nop%0d got %b exp %b", i, obs, e); end
    end
  endtask

  task automatic test_basic();
    step(PUSH, 3'd5); step(PUSH, 3'd2); step(PUSH, 3'd7);
    e = {1'b0, 3'd0, 3'd3, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL basic_fill got %b exp %b", obs, e); end
    step(REPLAY, 3'd0);
    e = {1'b1, 3'd5, 3'd2, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL basic_w0 got %b exp %b", obs, e); end
    step(NOP, 3'd0);
    e = {1'b1, 3'd2, 3'd1, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL basic_w1 got %b exp %b", obs, e); end
    step(NOP, 3'd0);
    e = {1'b1, 3'd7, 3'd0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL basic_w2 got %b exp %b", obs, e); end
    step(NOP, 3'd0);
    e = {1'b0, 3'd0, 3'd0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL basic_idle got %b exp %b", obs, e); end
  endtask

  task automatic test_overflow();
    step(PUSH, 3'd1); step(PUSH, 3'd2); step(PUSH, 3'd3); step(PUSH, 3'd4);
    e = {1'b0, 3'd0, 3'd4, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL ovf_full got %b exp %b", obs, e); end
    step(PUSH, 3'd6);
    e = {1'b0, 3'd0, 3'd4, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL ovf_drop got %b exp %b", obs, e); end
    step(REPLAY, 3'd0);
    for (int i = 0; i < 4; i++) begin
      e = {1'b1, 3'(i + 1), 3'(3 - i), 1'b1};
      checks++; if (obs !== e) begin errors++; $display("FAIL ovf_w%0d got %b exp %b", i, obs, e); end
      step(NOP, 3'd0);
    end
    e = {1'b0, 3'd0, 3'd0, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL ovf_idle got %b exp %b", obs, e); end
    step(CLEAR, 3'd0);
    e = {1'b0, 3'd0, 3'd0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL ovf_clear got %b exp %b", obs, e); end
  endtask

  task automatic test_wrap();
    step(PUSH, 3'd1); step(PUSH, 3'd2); step(PUSH, 3'd3);
    step(REPLAY, 3'd0);
    for (int i = 0; i < 3; i++) begin
      e = {1'b1, 3'(i + 1), 3'(2 - i), 1'b0};
      checks++; if (obs !== e) begin errors++; $display("FAIL wrap_a%0d got %b exp %b", i, obs, e); end
      if (i < 2) step(NOP, 3'd0);
    end
    step(PUSH, 3'd4); step(PUSH, 3'd5); step(PUSH, 3'd6); step(PUSH, 3'd7);
    e = {1'b0, 3'd0, 3'd4, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL wrap_fill got %b exp %b", obs, e); end
    step(REPLAY, 3'd0);
    for (int i = 0; i < 4; i++) begin
      e = {1'b1, 3'(i + 4), 3'(3 - i), 1'b0};
      checks++; if (obs !== e) begin errors++; $display("FAIL wrap_b%0d got %b exp %b", i, obs, e); end
      step(NOP, 3'd0);
    end
    e = {1'b0, 3'd0, 3'd0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL wrap_idle got %b exp %b", obs, e); end
  endtask

  task automatic test_abort();
    step(PUSH, 3'd1); step(PUSH, 3'd2); step(PUSH, 3'd3); step(PUSH, 3'd4);
    step(REPLAY, 3'd0);
    e = {1'b1, 3'd1, 3'd3, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL abort_w0 got %b exp %b", obs, e); end
    step(PUSH, 3'd5);
    e = {1'b1, 3'd2, 3'd2, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL abort_push got %b exp %b", obs, e); end
    step(CLEAR, 3'd0);
    e = {1'b0, 3'd0, 3'd0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL abort_clear got %b exp %b", obs, e); end
    step(NOP, 3'd0);
    checks++; if (obs !== e) begin errors++; $display("FAIL abort_idle got %b exp %b", obs, e); end
    step(PUSH, 3'd6);
    step(REPLAY, 3'd0);
    e = {1'b1, 3'd6, 3'd0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL abort_after got %b exp %b", obs, e); end
  endtask

  task automatic test_back_to_back();
    step(PUSH, 3'd3); step(PUSH, 3'd4);
    step(REPLAY, 3'd0);
    e = {1'b1, 3'd3, 3'd1, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL b2b_w0 got %b exp %b", obs, e); end
    step(REPLAY, 3'd0);
    e = {1'b1, 3'd4, 3'd0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL b2b_w1 got %b exp %b", obs, e); end
    step(REPLAY, 3'd0);
    e = {1'b0, 3'd0, 3'd0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL b2b_empty got %b exp %b", obs, e); end
  endtask

  task automatic test_async_reset();
    step(PUSH, 3'd1); step(PUSH, 3'd2); step(PUSH, 3'd3); step(PUSH, 3'd4); step(PUSH, 3'd5);
    e = {1'b0, 3'd0, 3'd4, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL arst_pre got %b exp %b", obs, e); end
    step(REPLAY, 3'd0);
    e = {1'b1, 3'd1, 3'd3, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL arst_w0 got %b exp %b", obs, e); end
    cmd = NOP;
    #2 rst = 1'b0;
    #1;
    e = {1'b0, 3'd0, 3'd0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL arst_now got %b exp %b", obs, e); end
    @(posedge clk);
    #1;
    checks++; if (obs !== e) begin errors++; $display("FAIL arst_hold got %b exp %b", obs, e); end
    rst = 1'b1;
    step(REPLAY, 3'd0);
    checks++; if (obs !== e) begin errors++; $display("FAIL arst_replay got %b exp %b", obs, e); end
    step(NOP, 3'd0);
    checks++; if (obs !== e) begin errors++; $display("FAIL arst_idle got %b exp %b", obs, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/resumption_replay_dev.md
Name: resumption_replay_dev

Overview:
- Parametrised successor to the team's small resumption-tag state devices.
- Adds a DEPTH-entry ring buffer and a 2-bit command input to the existing style of one-clock tag-register state machine with W-bit in/out.
- Operations: capture input words, replay them oldest-first with a valid strobe, or clear the buffer.
- Sits between a host stimulus port and a downstream consumer as a cycle-accurate capture/replay stage.

Parameters:
- W, 3, data width of __in0 and __out1 (≥1).
- DEPTH, 4, ring-buffer entries; power of two, ≥2.
- IDLE_VAL, 0, W-bit value driven on __out1 whenever __out0=0.
- CW is derived as $clog2(DEPTH+1); it is not user-set.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- __in0  input  W  data word.
- __in1  input  2  command: 0 NOP, 1 PUSH, 2 REPLAY, 3 CLEAR.
- __out0  output  1  data valid.
- __out1  output  W  replayed data; IDLE_VAL when not valid.
- __out2  output  CW  current occupancy count.
- __out3  output  1  sticky drop flag.

Behaviour:
- Async reset (rst=0, any time, including mid-replay):
  - state=IDLE, wr_ptr=0, rd_ptr=0, count=0.
  - __out0=0, __out1=IDLE_VAL, __out2=0, __out3=0.
  - Buffer contents are don't-care.
- Reset deassertion is taken synchronously. The first active edge is the first clk rise with rst=1.
- All outputs are registered and change only on a clk rise (or on reset). Commands are sampled on the rising edge.
- States: IDLE, REPLAY.
- IDLE, cmd NOP: no change; __out0=0.
- IDLE, cmd PUSH:
  - If count<DEPTH: mem[wr_ptr]<=__in0, wr_ptr<=(wr_ptr+1) mod DEPTH, count+1.
  - If count==DEPTH: word discarded, __out3<=1, nothing else changes.
  - __out0=0.
- IDLE, cmd REPLAY:
  - If count==0: no-op, stay IDLE, __out0=0.
  - Otherwise, on the same edge: __out0<=1, __out1<=mem[rd_ptr], rd_ptr+1 mod DEPTH, count-1. Next state is REPLAY if the new count>0, else IDLE.
  - Latency is 1 edge from command to first word.
- REPLAY (self-sequencing, one word per edge):
  - Each edge: __out0<=1, __out1<=mem[rd_ptr], rd_ptr advances, count decrements.
  - The edge that emits the last word moves to IDLE. The following edge drives __out0=0, __out1=IDLE_VAL.
  - cmd PUSH or REPLAY while in REPLAY: ignored for buffer/pointers; PUSH additionally sets __out3<=1.
  - cmd CLEAR while in REPLAY: abort. No word is emitted on that edge: __out0<=0, __out1<=IDLE_VAL, ptrs<=0, count<=0, __out3<=0, state<=IDLE.
- CLEAR in IDLE: ptrs<=0, count<=0, __out3<=0, __out0=0.
- __out2 always reflects count after the edge. Range 0..DEPTH; never wraps.
- Pointers wrap modulo DEPTH. Ordering is strictly FIFO across wrap boundaries.
- __out3 is cleared only by CLEAR or reset.
- Simultaneous events: a command and the internal last-word transition on the same edge resolve per the REPLAY rules above; CLEAR has highest priority.
- Implementation: the state encoding is folded into a single tag register {state, rd_ptr, wr_ptr, count}, consistent with other resumption devices.

Test Plan:
1. Reset: hold rst=0 two cycles, then release -> __out0=0, __out1=0, __out2=0, __out3=0; stays so with NOP for 4 edges.
2. W=3, DEPTH=4: PUSH 5, 2, 7, then REPLAY -> edge+1 __out1=5; then 2; then 7, each with __out0=1. __out2 goes 2, 1, 0. Next edge __out0=0, __out1=0.
3. Overflow: PUSH 1, 2, 3, 4, 6 -> __out2=4, __out3=1 after the 5th. REPLAY yields 1, 2, 3, 4 only. __out3 stays 1 until CLEAR.
4. Wrap: PUSH 1, 2, 3; REPLAY (3 words); PUSH 4, 5, 6, 7 (ptrs wrap); REPLAY -> 4, 5, 6, 7 in order.
5. Abort/ignored: PUSH 1, 2, 3, 4; REPLAY; on 2nd replay edge issue PUSH -> out 1, 2 and __out3=1. On 3rd replay edge issue CLEAR -> __out0=0, __out2=0, __out3=0, state IDLE.
6. Async reset mid-replay: drop rst between edges during REPLAY -> outputs go to reset values immediately, without a clock edge. After release, REPLAY is a no-op (count 0).
